// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared types and defaults for the register-file write-port controller
package wb_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int REG_AW   = $clog2(NREG_DEF);
  localparam int CNT_W    = 4;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FORCE = 2'd2
  } wb_state_e;

  typedef struct packed {
    logic                valid;
    reg_addr_t           addr;
    logic [XLEN_DEF-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - pending-destination scoreboard for long-latency results
module wb_scoreboard
  import wb_pkg::*;
#(
  parameter  int NREG = NREG_DEF,
  localparam int AW   = $clog2(NREG)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] rs1_addr,
  input  logic [AW-1:0] rs2_addr,
  input  logic [AW-1:0] rd_addr,
  output logic          rs1_pend,
  output logic          rs2_pend,
  output logic          rd_pend
);

  logic [NREG-1:0] pending_q;
  logic [NREG-1:0] pending_d;

  // Next pending vector: clear on the B handshake, then a same-cycle dispatch re-sets it
  always_comb begin
    pending_d = pending_q;
    if (clr_en) begin
      pending_d[clr_addr] = 1'b0;
    end
    if (set_en && (set_addr != '0)) begin
      pending_d[set_addr] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  // Pending register, cleared by reset so in-flight results are forgotten
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  // Lookup ports; x0 never carries a hazard
  always_comb begin
    rs1_pend = (rs1_addr != '0) & pending_q[rs1_addr];
    rs2_pend = (rs2_addr != '0) & pending_q[rs2_addr];
    rd_pend  = (rd_addr  != '0) & pending_q[rd_addr];
  end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// rtl/regfile_wb_ctrl.sv - shared regfile write port arbiter with hazard scoreboard; WB_BYPASS_EN enables B-result forwarding
module regfile_wb_ctrl
  import wb_pkg::*;
#(
  parameter  int XLEN         = XLEN_DEF,
  parameter  int NREG         = NREG_DEF,
  parameter  int STARVE_LIMIT = 4,
  localparam int AW           = $clog2(NREG)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            a_valid_i,
  input  logic [AW-1:0]   a_addr_i,
  input  logic [XLEN-1:0] a_data_i,
  input  logic            b_valid_i,
  input  logic [AW-1:0]   b_addr_i,
  input  logic [XLEN-1:0] b_data_i,
  output logic            b_ready_o,
  input  logic            lli_valid_i,
  input  logic [AW-1:0]   lli_addr_i,
  input  logic [AW-1:0]   rs1_addr_i,
  input  logic [AW-1:0]   rs2_addr_i,
  input  logic [AW-1:0]   rd_addr_i,
  output logic            hazard_o,
  output logic            stall_pipe_o,
  output logic            rd_wr_o,
  output logic [AW-1:0]   rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            fwd1_valid_o,
  output logic            fwd2_valid_o,
  output logic [XLEN-1:0] fwd_data_o
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic a_write;
  logic b_write;
  logic b_hs;
  logic rs1_pend;
  logic rs2_pend;
  logic rd_pend;
  logic byp1;
  logic byp2;

  wb_state_e        state_q;
  wb_state_e        state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             stall_q;

  // Grant: pipeline writeback always wins; B to x0 is accepted without a port write
  always_comb begin
    a_write   = a_valid_i & (a_addr_i != '0);
    b_write   = b_valid_i & (b_addr_i != '0);
    b_ready_o = b_valid_i & ~a_write & ~rst_i;
    b_hs      = b_ready_o;
  end

  // Regfile write port mux from the granted source
  always_comb begin
    rd_wr_o   = 1'b0;
    rd_addr_o = '0;
    rd_data_o = '0;
    if (!rst_i && a_write) begin
      rd_wr_o   = 1'b1;
      rd_addr_o = a_addr_i;
      rd_data_o = a_data_i;
    end else if (b_hs && b_write) begin
      rd_wr_o   = 1'b1;
      rd_addr_o = b_addr_i;
      rd_data_o = b_data_i;
    end
  end

  wb_scoreboard #(
    .NREG (NREG)
  ) u_scoreboard (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .set_en   (lli_valid_i),
    .set_addr (lli_addr_i),
    .clr_en   (b_hs),
    .clr_addr (b_addr_i),
    .rs1_addr (rs1_addr_i),
    .rs2_addr (rs2_addr_i),
    .rd_addr  (rd_addr_i),
    .rs1_pend (rs1_pend),
    .rs2_pend (rs2_pend),
    .rd_pend  (rd_pend)
  );

`ifdef WB_BYPASS_EN
  // Forward the B result to source operands in its handshake cycle
  always_comb begin
    byp1         = b_hs & b_write & (rs1_addr_i == b_addr_i);
    byp2         = b_hs & b_write & (rs2_addr_i == b_addr_i);
    fwd1_valid_o = byp1;
    fwd2_valid_o = byp2;
    fwd_data_o   = b_data_i;
  end
`else
  // No forwarding: consumers wait for the regfile to hold the result
  always_comb begin
    byp1         = 1'b0;
    byp2         = 1'b0;
    fwd1_valid_o = 1'b0;
    fwd2_valid_o = 1'b0;
    fwd_data_o   = '0;
  end
`endif

  // Decode stall: RAW on each source unless forwarded, WAW on the destination
  always_comb begin
    hazard_o = ~rst_i & ((rs1_pend & ~byp1) | (rs2_pend & ~byp2) | rd_pend);
  end

  // Starvation FSM next state: count blocked B cycles, then demand a bubble
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (b_valid_i && !b_hs) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT: begin
        if (!b_valid_i || b_hs) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LIMIT) begin
          state_d = FORCE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      FORCE: begin
        if (!b_valid_i || b_hs) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Starvation FSM registers; the bubble request is registered from the next state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      stall_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stall_q <= (state_d == FORCE);
    end
  end

  assign stall_pipe_o = stall_q;

endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Write-port controller for the single-write-port integer register file. Shares the port between the in-order pipeline writeback (fixed priority, never stalls) and a long-latency writeback source (loads, multi-cycle MUL/DIV) using a valid/ready handshake. Keeps a pending-destination scoreboard so decode can stall on RAW/WAW hazards against in-flight long-latency results. Sits between writeback/long-latency units and the regfile write port, and feeds the hazard input of the decode stall logic.

## Interface
- XLEN, 32, data width
- NREG, 32, architectural registers; address width is $clog2(NREG)
- STARVE_LIMIT, 4, consecutive blocked B cycles before a pipeline bubble is forced (range 1..15)

- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- a_valid_i / a_addr_i / a_data_i  in  1 / 5 / XLEN  pipeline writeback; no back-pressure
- b_valid_i / b_addr_i / b_data_i  in  1 / 5 / XLEN  long-latency result; held stable until accepted
- b_ready_o  out  1  B accepted this cycle
- lli_valid_i / lli_addr_i  in  1 / 5  long-latency op dispatched to rd lli_addr_i
- rs1_addr_i / rs2_addr_i / rd_addr_i  in  5 each  decode-stage operands
- hazard_o  out  1  decode must stall
- stall_pipe_o  out  1  forced bubble request to upstream pipeline
- rd_wr_o / rd_addr_o / rd_data_o  out  1 / 5 / XLEN  to regfile write port
- fwd1_valid_o / fwd2_valid_o / fwd_data_o  out  1 / 1 / XLEN  bypass (only with WB_BYPASS_EN)

## Operation
- a_write = a_valid_i & (a_addr_i != 0). b_write = b_valid_i & (b_addr_i != 0).
- Grant: a_write wins. b_ready_o = b_valid_i & !a_write & !rst_i. B with b_addr_i == 0 is accepted without a port write.
- Port mux: rd_wr_o = a_write | (b_ready_o & b_write); addr/data from the granted source, else 0.
- Scoreboard: pending[NREG-1:0]. Set bit on lli_valid_i (addr != 0). Clear bit b_addr_i on B handshake. Same-cycle set and clear on the same address: set wins. Bit 0 is never set.
- hazard_o = pending[rs1] | pending[rs2] | pending[rd] (WAW), ignoring index 0.
- Starvation FSM: IDLE, WAIT, FORCE.
  - IDLE -> WAIT: b_valid_i & !b_ready_o; counter loads 1.
  - WAIT: counter +1 per blocked cycle; counter == STARVE_LIMIT -> FORCE. Handshake -> IDLE.
  - FORCE: stall_pipe_o = 1. Upstream contract: a_valid_i = 0 in the following cycle. Handshake -> IDLE. Counter saturates at STARVE_LIMIT.
  - b_valid_i dropping without a handshake is illegal; the FSM returns to IDLE.

## Timing
- Port mux, b_ready_o and hazard_o are combinational. The regfile commits at the same posedge.
- The pending bit clears at the end of the handshake cycle. Without bypass, hazard_o stays high in that cycle; the consumer reads the regfile one cycle later.
- stall_pipe_o is registered: high the cycle after the counter reaches STARVE_LIMIT. Worst-case B wait is STARVE_LIMIT+2 cycles.
- Reset values: pending = 0, state = IDLE, counter = 0, stall_pipe_o = 0. While rst_i is high: b_ready_o = 0, rd_wr_o = 0, hazard_o = 0.
- Reset mid-operation drops the in-flight B request and clears all pending bits. Dispatching units are reset by the same rst_i.

## Configuration
- WB_BYPASS_EN defined: in the B handshake cycle, fwdN_valid_o = 1 when rsN matches b_addr_i (nonzero). fwd_data_o = b_data_i. hazard_o excludes that register's pending bit for that source operand; the WAW term is unaffected.
- WB_BYPASS_EN undefined: fwd outputs are tied 0 and hazard_o is purely scoreboard-based.

## Structure
- Package wb_pkg holds:
  - XLEN and NREG defaults
  - reg_addr_t typedef
  - wb_state_e enum (IDLE/WAIT/FORCE)
  - wb_req_t struct {valid, addr, data}
- Sub-module wb_scoreboard owns the pending vector, set/clear logic and the three lookup ports. The top level owns the grant logic, the FSM and bypass.

## Test plan
- A writes x5=0xDEAD0001 while B is idle -> rd_wr_o=1, addr 5; b_ready_o=0.
- A and B valid the same cycle, B to x7 -> A commits; B accepted in the first cycle with a_valid_i=0; x7 pending clears at that edge.
- lli to x9, then decode reads rs1=x9 -> hazard_o=1 until B writes x9. With WB_BYPASS_EN: fwd1_valid_o=1 and hazard_o=0 in the handshake cycle.
- A valid continuously, STARVE_LIMIT=4 -> stall_pipe_o rises after 4 blocked cycles. With A dropped, B accepted and FSM returns to IDLE.
- A writing x0 with B valid to x3 -> B granted the same cycle; B to x0 -> accepted, rd_wr_o=0.
- rst_i asserted while in FORCE with x2 and x4 pending -> next cycle: pending=0, stall_pipe_o=0, hazard_o=0.
